// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle instruction-sequencing FSM.
// It latches the opcode on each accepted instruction and steps through
// DECODE, EXEC, MEM and WB, producing the datapath control strobes for
// each step. HALT and ERROR are absorbing until reset. MEM has a wait
// timeout that sends the controller to ERROR.
// Optional feature: define MCTRL_RETIRE_CNT_EN to add a 32-bit
// retired_cnt output that counts pc_write cycles.
module multicycle_controller #(
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned TMO_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                sel_ALUScr_reg,
  output logic                sel_ALUScr_const,
  output logic                sel_PCSrc_plus1,
  output logic                sel_PCSrc_offset,
  output logic                sel_PCSrc_const,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                sel_RegisterFile_in_alu,
  output logic                sel_RegisterFile_in_memory,
  output logic                sel_RegisterFile_in_shifter,
  output logic                sel_RegisterFileWriteDst_r2,
  output logic                sel_RegisterFileReadReg2_rd,
  output logic                RegisterFileWriteEn,
  output logic                pc_write,
  output logic                halted,
  output logic                err
`ifdef MCTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]         retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [3:0] {
    C_REG, C_IMM, C_SHIFT, C_STM, C_LDM, C_ILL, C_CJMP, C_JMP, C_HALT
  } iclass_t;

  // Last MEM wait cycle that may still complete: one short of 2^TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [5:0]       ir_q, ir_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  iclass_t          iclass;

  // Instruction class decode of the latched opcode.
  always_comb begin
    iclass = C_ILL;
    if (ir_q[5:4] == 2'b00)      iclass = C_REG;
    else if (ir_q[5:4] == 2'b01) iclass = C_IMM;
    else if (ir_q[5:3] == 3'b100) iclass = C_SHIFT;
    else if (ir_q[5:3] == 3'b101) begin
      if (ir_q[2:1] == 2'b00)      iclass = C_STM;
      else if (ir_q[2:1] == 2'b01) iclass = C_LDM;
      else                         iclass = C_ILL;
    end
    else if (ir_q[5:3] == 3'b110) iclass = C_CJMP;
    else if (ir_q[5:2] == 4'b1110) iclass = C_JMP;
    else                          iclass = C_HALT;
  end

  // State, instruction register and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    state_d                     = state_q;
    ir_d                        = ir_q;
    tmo_d                       = tmo_q;
    instr_ready                 = 1'b0;
    ALU_op                      = '0;
    sel_ALUScr_reg              = 1'b0;
    sel_ALUScr_const            = 1'b0;
    sel_PCSrc_plus1             = 1'b0;
    sel_PCSrc_offset            = 1'b0;
    sel_PCSrc_const             = 1'b0;
    MemRead                     = 1'b0;
    MemWrite                    = 1'b0;
    sel_RegisterFile_in_alu     = 1'b0;
    sel_RegisterFile_in_memory  = 1'b0;
    sel_RegisterFile_in_shifter = 1'b0;
    sel_RegisterFileWriteDst_r2 = 1'b0;
    sel_RegisterFileReadReg2_rd = 1'b0;
    RegisterFileWriteEn         = 1'b0;
    pc_write                    = 1'b0;
    halted                      = 1'b0;
    err                         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = opcode;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        tmo_d = '0;
        unique case (iclass)
          C_STM, C_LDM: state_d = S_MEM;
          C_HALT:       state_d = S_HALT;
          C_ILL:        state_d = S_ERROR;
          default:      state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        unique case (iclass)
          C_REG: begin
            sel_ALUScr_reg = 1'b1;
            ALU_op         = ir_q[ALU_OP_W-1:0];
            state_d        = S_WB;
          end
          C_IMM: begin
            sel_ALUScr_const = 1'b1;
            ALU_op           = ir_q[ALU_OP_W-1:0];
            state_d          = S_WB;
          end
          C_SHIFT: state_d = S_WB;
          C_CJMP: begin
            pc_write         = 1'b1;
            sel_PCSrc_offset = zero_flag;
            sel_PCSrc_plus1  = ~zero_flag;
            state_d          = S_IDLE;
          end
          C_JMP: begin
            pc_write        = 1'b1;
            sel_PCSrc_const = 1'b1;
            state_d         = S_IDLE;
          end
          default: state_d = S_ERROR;
        endcase
      end

      S_MEM: begin
        sel_ALUScr_const = 1'b1;
        if (iclass == C_STM) begin
          MemWrite                    = 1'b1;
          sel_RegisterFileReadReg2_rd = 1'b1;
        end else begin
          MemRead                     = 1'b1;
          sel_RegisterFile_in_memory  = 1'b1;
          sel_RegisterFileWriteDst_r2 = 1'b1;
        end
        // A completion on the last allowed cycle takes priority over the timeout.
        if (mem_ready) begin
          if (iclass == C_STM) begin
            pc_write        = 1'b1;
            sel_PCSrc_plus1 = 1'b1;
            state_d         = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WB: begin
        RegisterFileWriteEn = 1'b1;
        pc_write            = 1'b1;
        sel_PCSrc_plus1     = 1'b1;
        unique case (iclass)
          C_SHIFT: sel_RegisterFile_in_shifter = 1'b1;
          C_LDM: begin
            sel_RegisterFile_in_memory  = 1'b1;
            sel_RegisterFileWriteDst_r2 = 1'b1;
          end
          default: sel_RegisterFile_in_alu = 1'b1;
        endcase
        state_d = S_IDLE;
      end

      S_HALT:  halted = 1'b1;
      S_ERROR: err    = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

`ifdef MCTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  // Count every cycle that updates the PC; wraps naturally at 2^32.
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, pc_write};
  end

  // Retirement counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt_q <= '0;
    else     retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (default build).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       instr_valid = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       instr_ready;
  logic [2:0] ALU_op;
  logic sel_ALUScr_reg, sel_ALUScr_const, sel_PCSrc_plus1, sel_PCSrc_offset;
  logic sel_PCSrc_const, MemRead, MemWrite, sel_RegisterFile_in_alu;
  logic sel_RegisterFile_in_memory, sel_RegisterFile_in_shifter;
  logic sel_RegisterFileWriteDst_r2, sel_RegisterFileReadReg2_rd;
  logic RegisterFileWriteEn, pc_write, halted, err;

  int n_cmp = 0;
  int n_err = 0;
  int mem_cycles;

  multicycle_controller #(.ALU_OP_W(3), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .ALU_op(ALU_op), .sel_ALUScr_reg(sel_ALUScr_reg),
    .sel_ALUScr_const(sel_ALUScr_const), .sel_PCSrc_plus1(sel_PCSrc_plus1),
    .sel_PCSrc_offset(sel_PCSrc_offset), .sel_PCSrc_const(sel_PCSrc_const),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .sel_RegisterFile_in_alu(sel_RegisterFile_in_alu),
    .sel_RegisterFile_in_memory(sel_RegisterFile_in_memory),
    .sel_RegisterFile_in_shifter(sel_RegisterFile_in_shifter),
    .sel_RegisterFileWriteDst_r2(sel_RegisterFileWriteDst_r2),
    .sel_RegisterFileReadReg2_rd(sel_RegisterFileReadReg2_rd),
    .RegisterFileWriteEn(RegisterFileWriteEn), .pc_write(pc_write),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction at a falling edge; it is accepted on the next rising edge.
  task automatic accept(input logic [5:0] op);
    opcode      = op;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready",  instr_ready, 1);
    chk("rst_pcw",    pc_write, 0);
    chk("rst_aluop",  ALU_op, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err",    err, 0);
    @(negedge clk) rst = 1'b0;

    // REG opcode 000011
    @(negedge clk) accept(6'b000011);
    @(negedge clk);
    chk("reg_dec_ready", instr_ready, 0);
    chk("reg_dec_aluop", ALU_op, 0);
    @(negedge clk);
    chk("reg_ex_aluop", ALU_op, 3);
    chk("reg_ex_srcreg", sel_ALUScr_reg, 1);
    chk("reg_ex_srcconst", sel_ALUScr_const, 0);
    chk("reg_ex_wen", RegisterFileWriteEn, 0);
    @(negedge clk);
    chk("reg_wb_wen", RegisterFileWriteEn, 1);
    chk("reg_wb_pcw", pc_write, 1);
    chk("reg_wb_plus1", sel_PCSrc_plus1, 1);
    chk("reg_wb_inalu", sel_RegisterFile_in_alu, 1);
    chk("reg_wb_aluop", ALU_op, 0);
    @(negedge clk);
    chk("reg_idle_ready", instr_ready, 1);

    // IMM opcode 010101
    accept(6'b010101);
    @(negedge clk); @(negedge clk);
    chk("imm_ex_aluop", ALU_op, 5);
    chk("imm_ex_srcconst", sel_ALUScr_const, 1);
    chk("imm_ex_srcreg", sel_ALUScr_reg, 0);
    @(negedge clk);
    chk("imm_wb_inalu", sel_RegisterFile_in_alu, 1);
    chk("imm_wb_wen", RegisterFileWriteEn, 1);

    // SHIFT opcode 100000
    @(negedge clk) accept(6'b100000);
    @(negedge clk); @(negedge clk);
    chk("sh_ex_wen", RegisterFileWriteEn, 0);
    @(negedge clk);
    chk("sh_wb_inshift", sel_RegisterFile_in_shifter, 1);
    chk("sh_wb_inalu", sel_RegisterFile_in_alu, 0);
    chk("sh_wb_wen", RegisterFileWriteEn, 1);

    // LDM opcode 101010, mem_ready on the 3rd MEM cycle
    @(negedge clk) accept(6'b101010);
    @(negedge clk);
    chk("ldm_dec_memrd", MemRead, 0);
    @(negedge clk);
    chk("ldm_mem1_memrd", MemRead, 1);
    chk("ldm_mem1_const", sel_ALUScr_const, 1);
    @(negedge clk);
    chk("ldm_mem2_memrd", MemRead, 1);
    @(negedge clk);
    chk("ldm_mem3_memrd", MemRead, 1);
    chk("ldm_mem3_dst", sel_RegisterFileWriteDst_r2, 1);
    mem_ready = 1'b1;
    #1 chk("ldm_mem3_pcw", pc_write, 0);
    @(posedge clk) #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("ldm_wb_memrd", MemRead, 0);
    chk("ldm_wb_inmem", sel_RegisterFile_in_memory, 1);
    chk("ldm_wb_dst", sel_RegisterFileWriteDst_r2, 1);
    chk("ldm_wb_wen", RegisterFileWriteEn, 1);
    chk("ldm_wb_pcw", pc_write, 1);

    // STM opcode 101000, immediate completion
    @(negedge clk) accept(6'b101000);
    @(negedge clk); @(negedge clk);
    chk("stm_mem_memwr", MemWrite, 1);
    chk("stm_mem_rd2", sel_RegisterFileReadReg2_rd, 1);
    chk("stm_mem_pcw0", pc_write, 0);
    mem_ready = 1'b1;
    #1;
    chk("stm_done_pcw", pc_write, 1);
    chk("stm_done_plus1", sel_PCSrc_plus1, 1);
    @(posedge clk) #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("stm_idle_ready", instr_ready, 1);
    chk("stm_idle_memwr", MemWrite, 0);

    // CJMP taken and not taken
    zero_flag = 1'b1;
    accept(6'b110000);
    @(negedge clk); @(negedge clk);
    chk("cj1_pcw", pc_write, 1);
    chk("cj1_offset", sel_PCSrc_offset, 1);
    chk("cj1_plus1", sel_PCSrc_plus1, 0);
    @(negedge clk);
    chk("cj1_idle", instr_ready, 1);
    zero_flag = 1'b0;
    accept(6'b110000);
    @(negedge clk); @(negedge clk);
    chk("cj0_offset", sel_PCSrc_offset, 0);
    chk("cj0_plus1", sel_PCSrc_plus1, 1);
    chk("cj0_pcw", pc_write, 1);

    // JMP opcode 111000
    @(negedge clk) accept(6'b111000);
    @(negedge clk);
    chk("jmp_dec_pcw", pc_write, 0);
    @(negedge clk);
    chk("jmp_ex_pcw", pc_write, 1);
    chk("jmp_ex_const", sel_PCSrc_const, 1);
    @(negedge clk);
    chk("jmp_idle", instr_ready, 1);

    // Illegal MEM function -> ERROR
    accept(6'b101100);
    @(negedge clk); @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_ready", instr_ready, 0);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // STM timeout: 15 MEM cycles then ERROR
    accept(6'b101000);
    @(negedge clk);
    mem_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (MemWrite) mem_cycles++;
      else break;
    end
    chk("tmo_cycles", mem_cycles, 15);
    chk("tmo_err", err, 1);
    opcode = 6'b000011;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tmo_stuck_ready", instr_ready, 0);
      chk("tmo_stuck_err", err, 1);
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // mem_ready on the limit cycle wins over the timeout
    accept(6'b101000);
    @(negedge clk);
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk("lim14_memwr", MemWrite, 1);
    @(negedge clk);
    chk("lim15_memwr", MemWrite, 1);
    mem_ready = 1'b1;
    #1 chk("lim15_pcw", pc_write, 1);
    @(posedge clk) #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("lim_err", err, 0);
    chk("lim_ready", instr_ready, 1);

    // Asynchronous reset during LDM MEM
    accept(6'b101010);
    @(negedge clk); @(negedge clk);
    chk("arst_pre_memrd", MemRead, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_memrd", MemRead, 0);
    chk("arst_ready", instr_ready, 1);
    chk("arst_const", sel_ALUScr_const, 0);
    @(negedge clk) rst = 1'b0;

    // HALT opcode 111100
    accept(6'b111100);
    @(negedge clk);
    chk("halt_c1", halted, 0);
    @(negedge clk);
    chk("halt_c2", halted, 1);
    chk("halt_ready", instr_ready, 0);
    opcode = 6'b000011;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_stay", halted, 1);
      chk("halt_nowen", RegisterFileWriteEn, 0);
      chk("halt_noaccept", instr_ready, 0);
    end
    instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
